// File: rtl/song_tutor_multi.sv
// song_tutor_multi: play-along tutor for the FPGA piano.
//
// Holds NUM_SONGS user-loadable note sequences and lights the LED of the next
// expected note. A correct press followed by a release advances to the next
// note. Wrong presses are counted once each, however long they are held.
//
// Optional feature macro: SONG_TUTOR_LOOP_EN
//   defined   -> after the last note is released the song restarts at idx 0
//                (err_cnt kept); DONE is reached only for an empty song.
//   undefined -> the song ends in DONE.
//
// Ports:
//   CLK, RESET         clock, synchronous active-high reset
//   START, song_sel    one-cycle (re)start pulse and the slot it selects
//   note               debounced key code, 0 = no key
//   wr_en/wr_song/wr_addr/wr_note   song RAM write port
//   len_we/wr_len      per-slot length write (clamped to MAX_LEN)
//   Led                expected-note indicator (registered)
//   idx, err_cnt       current note index, saturating wrong-press count
//   busy, done         state decodes
//
// state   | meaning
// --------+-------------------------------------------------
// IDLE    | waiting for START, LEDs off
// PRESS   | waiting for the expected key
// RELEASE | correct key is down, waiting for release
// WRONG   | wrong key is down (already counted), waiting for release
// DONE    | song finished or empty, all LEDs lit

module song_tutor_multi #(
    parameter int  NOTE_W    = 4,
    parameter int  LED_W     = 8,
    parameter int  ADDR_W    = 6,
    parameter int  NUM_SONGS = 4,
    parameter int  ERR_W     = 8,
    localparam int SEL_W     = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [SEL_W-1:0]  song_sel,
    input  logic [NOTE_W-1:0] note,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_song,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [NOTE_W-1:0] wr_note,
    input  logic              len_we,
    input  logic [ADDR_W:0]   wr_len,
    output logic [LED_W-1:0]  Led,
    output logic [ADDR_W-1:0] idx,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int              MAX_LEN   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] MAX_LEN_V = (ADDR_W + 1)'(MAX_LEN);
    localparam logic [ADDR_W:0] ONE_EXT   = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_RELEASE,
        S_WRONG,
        S_DONE
    } state_t;

    logic [NOTE_W-1:0] ram_q [NUM_SONGS][MAX_LEN];
    logic [ADDR_W:0]   len_q [NUM_SONGS];

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  song_q,  song_d;
    logic [ADDR_W-1:0] idx_q,   idx_d;
    logic [ERR_W-1:0]  err_q,   err_d;
    logic [LED_W-1:0]  led_q,   led_d;

    logic [NOTE_W-1:0] exp_note;
    logic [ADDR_W:0]   cur_len;
    logic [ADDR_W:0]   start_len;
    logic              last_note;

    // Slot numbers beyond NUM_SONGS (non power-of-two counts) read as empty.
    function automatic logic song_ok(input logic [SEL_W-1:0] s);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < NUM_SONGS; i++) begin
            if (s == SEL_W'(i)) ok = 1'b1;
        end
        return ok;
    endfunction

    // Codes outside 1..LED_W light nothing.
    function automatic logic [LED_W-1:0] onehot(input logic [NOTE_W-1:0] c);
        logic [LED_W-1:0] v;
        v = '0;
        for (int i = 0; i < LED_W; i++) begin
            if (int'(c) == i + 1) v[i] = 1'b1;
        end
        return v;
    endfunction

    // Song storage: not reset, so loaded songs survive RESET.
    always_ff @(posedge CLK) begin
        if (wr_en && song_ok(wr_song)) begin
            ram_q[wr_song][wr_addr] <= wr_note;
        end
        if (len_we && song_ok(wr_song)) begin
            len_q[wr_song] <= (wr_len > MAX_LEN_V) ? MAX_LEN_V : wr_len;
        end
    end

    always_comb begin
        exp_note  = '0;
        cur_len   = '0;
        start_len = '0;
        if (song_ok(song_q)) begin
            exp_note = ram_q[song_q][idx_q];
            cur_len  = len_q[song_q];
        end
        if (song_ok(song_sel)) begin
            start_len = len_q[song_sel];
        end
    end

    // ">=" rather than "==" so a length shrunk below idx mid-song still ends it.
    assign last_note = ({1'b0, idx_q} + ONE_EXT) >= cur_len;

    always_comb begin
        state_d = state_q;
        song_d  = song_q;
        idx_d   = idx_q;
        err_d   = err_q;

        // Led reflects the current state/idx, so it lags a change by one cycle.
        case (state_q)
            S_IDLE:  led_d = '0;
            S_DONE:  led_d = '1;
            default: led_d = onehot(exp_note);
        endcase

        if (START) begin
            song_d  = song_sel;
            idx_d   = '0;
            err_d   = '0;
            state_d = (start_len == '0) ? S_DONE : S_PRESS;
        end else begin
            case (state_q)
                S_PRESS: begin
                    // A stored 0 never matches: note is nonzero here.
                    if (note != '0) begin
                        if (note == exp_note) begin
                            state_d = S_RELEASE;
                        end else begin
                            if (err_q != '1) err_d = err_q + ERR_W'(1);
                            state_d = S_WRONG;
                        end
                    end
                end
                S_RELEASE: begin
                    if (note == '0) begin
                        if (last_note) begin
`ifdef SONG_TUTOR_LOOP_EN
                            idx_d   = '0;
                            state_d = S_PRESS;
`else
                            state_d = S_DONE;
`endif
                        end else begin
                            idx_d   = idx_q + ADDR_W'(1);
                            state_d = S_PRESS;
                        end
                    end
                end
                S_WRONG: begin
                    if (note == '0) state_d = S_PRESS;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= S_IDLE;
            song_q  <= '0;
            idx_q   <= '0;
            err_q   <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            song_q  <= song_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            led_q   <= led_d;
        end
    end

    assign Led     = led_q;
    assign idx     = idx_q;
    assign err_cnt = err_q;
    assign busy    = (state_q == S_PRESS) || (state_q == S_RELEASE) || (state_q == S_WRONG);
    assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_song_tutor_multi.sv
// Testbench for song_tutor_multi. Two instances share all inputs: the default
// build and one with ERR_W=2 for saturation. A small behavioural model pushes
// the expected post-edge outputs to a queue as each cycle is driven; a monitor
// pops and compares on the following falling edge. Directed checks at key
// points compare against hand-derived constants.
// Honours SONG_TUTOR_LOOP_EN when it is defined for the build.

module tb_song_tutor_multi;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       RESET, START;
    logic [1:0] song_sel;
    logic [3:0] note;
    logic       wr_en;
    logic [1:0] wr_song;
    logic [5:0] wr_addr;
    logic [3:0] wr_note;
    logic       len_we;
    logic [6:0] wr_len;

    logic [7:0] led1, led2;
    logic [5:0] idx1, idx2;
    logic       busy1, busy2, done1, done2;
    logic [7:0] err1;
    logic [1:0] err2;

    song_tutor_multi dut1 (
        .CLK(CLK), .RESET(RESET), .START(START), .song_sel(song_sel), .note(note),
        .wr_en(wr_en), .wr_song(wr_song), .wr_addr(wr_addr), .wr_note(wr_note),
        .len_we(len_we), .wr_len(wr_len),
        .Led(led1), .idx(idx1), .busy(busy1), .done(done1), .err_cnt(err1)
    );

    song_tutor_multi #(.ERR_W(2)) dut2 (
        .CLK(CLK), .RESET(RESET), .START(START), .song_sel(song_sel), .note(note),
        .wr_en(wr_en), .wr_song(wr_song), .wr_addr(wr_addr), .wr_note(wr_note),
        .len_we(len_we), .wr_len(wr_len),
        .Led(led2), .idx(idx2), .busy(busy2), .done(done2), .err_cnt(err2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    typedef struct packed {
        logic [7:0] led;
        logic [5:0] idx;
        logic [7:0] err8;
        logic [1:0] err2;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t sb[$];

    localparam int M_IDLE = 0, M_PRESS = 1, M_REL = 2, M_WRONG = 3, M_DONE = 4;

    int m_st = M_IDLE, m_song = 0, m_idx = 0, m_err = 0, m_led = 0;
    int m_ram [4][64];
    int m_len [4];

    function automatic int led_of(input int st, input int code);
        if (st == M_IDLE) return 0;
        if (st == M_DONE) return 255;
        if (code >= 1 && code <= 8) return 1 << (code - 1);
        return 0;
    endfunction

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int   e, nled;
        exp_t x;
        e    = m_ram[m_song][m_idx];
        nled = led_of(m_st, e);
        if (RESET) begin
            m_st = M_IDLE; m_idx = 0; m_err = 0; m_led = 0; m_song = 0;
        end else begin
            if (START) begin
                m_song = int'(song_sel);
                m_idx  = 0;
                m_err  = 0;
                m_st   = (m_len[song_sel] == 0) ? M_DONE : M_PRESS;
            end else begin
                case (m_st)
                    M_PRESS: if (note != 0) begin
                        if (int'(note) == e) m_st = M_REL;
                        else begin m_err++; m_st = M_WRONG; end
                    end
                    M_REL: if (note == 0) begin
                        if (m_idx == m_len[m_song] - 1) begin
`ifdef SONG_TUTOR_LOOP_EN
                            m_idx = 0; m_st = M_PRESS;
`else
                            m_st = M_DONE;
`endif
                        end else begin
                            m_idx++; m_st = M_PRESS;
                        end
                    end
                    M_WRONG: if (note == 0) m_st = M_PRESS;
                    default: ;
                endcase
            end
            m_led = nled;
        end
        if (wr_en)  m_ram[wr_song][wr_addr] = int'(wr_note);
        if (len_we) m_len[wr_song] = (wr_len > 64) ? 64 : int'(wr_len);

        x.led  = 8'(m_led);
        x.idx  = 6'(m_idx);
        x.err8 = (m_err > 255) ? 8'd255 : 8'(m_err);
        x.err2 = (m_err > 3) ? 2'd3 : 2'(m_err);
        x.busy = (m_st == M_PRESS) || (m_st == M_REL) || (m_st == M_WRONG);
        x.done = (m_st == M_DONE);
        sb.push_back(x);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("led",   32'(led1),  32'(e.led));
            chk("idx",   32'(idx1),  32'(e.idx));
            chk("err8",  32'(err1),  32'(e.err8));
            chk("busy",  32'(busy1), 32'(e.busy));
            chk("done",  32'(done1), 32'(e.done));
            chk("led2",  32'(led2),  32'(e.led));
            chk("idx2",  32'(idx2),  32'(e.idx));
            chk("err2",  32'(err2),  32'(e.err2));
            chk("done2", 32'(done2), 32'(e.done));
            chk("busy2", 32'(busy2), 32'(e.busy));
        end
    end

    // One clock: drive inputs, record expectation, return just after the
    // falling edge so outputs are settled for directed checks.
    task automatic cyc(input logic s, input int sel, input int n);
        START    = s;
        song_sel = 2'(sel);
        note     = 4'(n);
        model_step();
        @(negedge CLK);
        #1;
        START = 1'b0;
    endtask

    task automatic play(input int n);
        cyc(1'b0, 0, n);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 0, 0);
    endtask

    task automatic put_note(input int song, input int addr, input int n);
        wr_en = 1'b1; wr_song = 2'(song); wr_addr = 6'(addr); wr_note = 4'(n);
        cyc(1'b0, 0, 0);
        wr_en = 1'b0;
    endtask

    task automatic put_len(input int song, input int len);
        len_we = 1'b1; wr_song = 2'(song); wr_len = 7'(len);
        cyc(1'b0, 0, 0);
        len_we = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; START = 1'b0; song_sel = '0; note = '0;
        wr_en = 1'b0; wr_song = '0; wr_addr = '0; wr_note = '0;
        len_we = 1'b0; wr_len = '0;
        idle(2);
        RESET = 1'b0;
        chk("rst_led",  32'(led1),  32'h0);
        chk("rst_idx",  32'(idx1),  32'h0);
        chk("rst_busy", 32'(busy1), 32'h0);
        chk("rst_done", 32'(done1), 32'h0);

        put_note(1, 0, 1); put_note(1, 1, 2); put_note(1, 2, 3); put_len(1, 3);
        put_len(2, 0);
        put_note(0, 0, 12); put_note(0, 1, 0); put_len(0, 2);

        // Full play of [1,2,3]
        cyc(1'b1, 1, 0);
        play(1);          chk("a_led0", 32'(led1), 32'h01);
        play(0); play(2); chk("a_led1", 32'(led1), 32'h02);
        play(0); play(3); chk("a_led2", 32'(led1), 32'h04);
        play(0); idle(2);
`ifdef SONG_TUTOR_LOOP_EN
        chk("a_loop_idx",  32'(idx1),  32'h0);
        chk("a_loop_led",  32'(led1),  32'h01);
        chk("a_loop_done", 32'(done1), 32'h0);
`else
        chk("a_done", 32'(done1), 32'h1);
        chk("a_led",  32'(led1),  32'hFF);
`endif
        chk("a_err", 32'(err1), 32'h0);

        // Long wrong press counts once
        cyc(1'b1, 1, 0);
        for (int i = 0; i < 10; i++) play(5);
        play(0); play(1); play(0); idle(1);
        chk("b_err", 32'(err1), 32'h1);
        chk("b_idx", 32'(idx1), 32'h1);
        chk("b_led", 32'(led1), 32'h02);

        // Long correct press advances once
        for (int i = 0; i < 20; i++) play(2);
        play(0);
        chk("c_idx", 32'(idx1), 32'h2);

        // START wins over a simultaneous key
        play(5); play(0); play(6); play(0);
        chk("d_err_pre", 32'(err1), 32'h3);
        cyc(1'b1, 1, 1);
        chk("d_idx",  32'(idx1),  32'h0);
        chk("d_err",  32'(err1),  32'h0);
        chk("d_busy", 32'(busy1), 32'h1);
        play(1); play(0);

        // Saturation on the narrow counter
        cyc(1'b1, 1, 0);
        for (int i = 0; i < 5; i++) begin play(7); play(0); end
        chk("e_err2", 32'(err2), 32'h3);
        chk("e_err8", 32'(err1), 32'h5);

        // Empty song
        cyc(1'b1, 2, 0);
        chk("f_done", 32'(done1), 32'h1);
        idle(1);
        chk("f_led", 32'(led1), 32'hFF);

        // Code outside the LED range, then a stored 0 that stalls
        cyc(1'b1, 0, 0); idle(1);
        chk("g_led", 32'(led1), 32'h0);
        play(12); play(0);
        chk("g_idx", 32'(idx1), 32'h1);
        play(1); play(0); play(3); play(0);
        chk("g_err",  32'(err1),  32'h2);
        chk("g_stall", 32'(idx1), 32'h1);

        // Rewrite the active note mid-song
        cyc(1'b1, 1, 0);
        put_note(1, 0, 4); idle(1);
        chk("h_led", 32'(led1), 32'h08);
        play(4); play(0);
        chk("h_idx", 32'(idx1), 32'h1);
        put_note(1, 0, 1);

        // Reset mid-song keeps the RAM
        RESET = 1'b1; idle(1); RESET = 1'b0;
        chk("i_led",  32'(led1),  32'h0);
        chk("i_busy", 32'(busy1), 32'h0);
        cyc(1'b1, 1, 0);
        play(1); play(0); play(2); play(0); play(3); play(0); idle(2);
`ifdef SONG_TUTOR_LOOP_EN
        chk("i_loop_idx", 32'(idx1), 32'h0);
`else
        chk("i_done", 32'(done1), 32'h1);
`endif

        // Oversized length clamps to 64 notes
        for (int a = 0; a < 64; a++) put_note(3, a, 2);
        put_len(3, 100);
        cyc(1'b1, 3, 0);
        for (int i = 0; i < 64; i++) begin play(2); play(0); end
        idle(1);
`ifdef SONG_TUTOR_LOOP_EN
        chk("j_loop_idx",  32'(idx1),  32'h0);
        chk("j_loop_busy", 32'(busy1), 32'h1);
`else
        chk("j_done", 32'(done1), 32'h1);
`endif

        // START leaves DONE (or restarts a looping song)
        cyc(1'b1, 1, 0);
        chk("k_busy", 32'(busy1), 32'h1);
        chk("k_done", 32'(done1), 32'h0);
        idle(3);

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
